// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter
//   Modulo up/down counter with an enable prescaler, synchronous parallel load
//   (clamped to MODULUS-1) and a registered one-cycle wrap pulse.
//
// Parameters
//   WIDTH   : width of count_out / load_value
//   MODULUS : number of count states, 2..2^WIDTH
//   DIV     : enabled cycles per count step, >= 1
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   enable     in   advances the prescaler
//   up_down    in   1 = up, 0 = down, sampled on each step
//   load       in   parallel load of load_value (clamped)
//   load_value in   [WIDTH] load data
//   count_out  out  [WIDTH] registered count
//   wrap       out  registered pulse, high in the cycle the wrapped value appears
//   zero       out  registered, 1 when count_out == 0
//
// Build option
//   COUNTER_SATURATE_EN : when defined, the count saturates at 0 / MODULUS-1
//                         instead of wrapping, and wrap stays 0.
module prescaled_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int DIV     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap,
  output logic             zero
);

  localparam int               PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2^WIDTH is representable for the clamp test.
  localparam logic [WIDTH:0]   MOD_W    = (WIDTH + 1)'(MODULUS);

  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_zero;

  logic             w_step;
  logic [WIDTH-1:0] w_load_val;
  logic [PW-1:0]    w_pre_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;

  always_comb begin
    w_step     = enable && (r_pre == PRE_LAST);
    w_load_val = ({1'b0, load_value} >= MOD_W) ? CNT_MAX : load_value;
    w_pre_nxt  = r_pre;
    w_cnt_nxt  = r_count;
    w_wrap_nxt = 1'b0;
    if (load) begin
      // Load wins over a coincident step and restarts the prescale period.
      w_cnt_nxt = w_load_val;
      w_pre_nxt = '0;
    end else begin
      if (enable)
        w_pre_nxt = w_step ? '0 : r_pre + PW'(1);
      if (w_step) begin
        if (up_down) begin
          if (r_count == CNT_MAX) begin
`ifdef COUNTER_SATURATE_EN
            w_cnt_nxt  = CNT_MAX;
`else
            w_cnt_nxt  = '0;
            w_wrap_nxt = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_count + WIDTH'(1);
          end
        end else begin
          if (r_count == '0) begin
`ifdef COUNTER_SATURATE_EN
            w_cnt_nxt  = '0;
`else
            w_cnt_nxt  = CNT_MAX;
            w_wrap_nxt = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_count - WIDTH'(1);
          end
        end
      end
    end
  end

  // zero is derived from the next count so it lands in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre   <= '0;
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_pre   <= w_pre_nxt;
      r_count <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
      r_zero  <= (w_cnt_nxt == '0);
    end
  end

  assign count_out = r_count;
  assign wrap      = r_wrap;
  assign zero      = r_zero;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
module tb_prescaled_updown_counter;

  localparam int N = 3;
  // Instance 0: MOD 10 DIV 1, instance 1: MOD 10 DIV 3, instance 2: MOD 16 DIV 2
  localparam int MODS [N] = '{10, 10, 16};
  localparam int DIVS [N] = '{1, 3, 2};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;

  logic [3:0] cnt_o  [N];
  logic       wrap_o [N];
  logic       zero_o [N];

  int nchk = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  prescaled_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_d1 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value),
    .count_out(cnt_o[0]), .wrap(wrap_o[0]), .zero(zero_o[0]));

  prescaled_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(3)) u_d3 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value),
    .count_out(cnt_o[1]), .wrap(wrap_o[1]), .zero(zero_o[1]));

  prescaled_updown_counter #(.WIDTH(4), .MODULUS(16), .DIV(2)) u_m16 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value),
    .count_out(cnt_o[2]), .wrap(wrap_o[2]), .zero(zero_o[2]));

  // Behavioural model: integer count, integer prescale position, wrap flag.
  int m_cnt  [N];
  int m_pre  [N];
  int m_wrap [N];
  bit m_valid = 1'b0;
  bit sat;

  initial begin
`ifdef COUNTER_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
  end

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
      end else if (load) begin
        m_cnt[i]  = (int'(load_value) >= MODS[i]) ? MODS[i] - 1 : int'(load_value);
        m_pre[i]  = 0;
        m_wrap[i] = 0;
      end else begin
        m_wrap[i] = 0;
        if (enable) begin
          if (m_pre[i] + 1 == DIVS[i]) begin
            m_pre[i] = 0;
            if (up_down) begin
              if (m_cnt[i] + 1 < MODS[i]) m_cnt[i] = m_cnt[i] + 1;
              else if (!sat) begin m_cnt[i] = 0; m_wrap[i] = 1; end
            end else begin
              if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
              else if (!sat) begin m_cnt[i] = MODS[i] - 1; m_wrap[i] = 1; end
            end
          end else begin
            m_pre[i] = m_pre[i] + 1;
          end
        end
      end
    end
    if (reset) m_valid = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("model_cnt[%0d]", i),  int'(cnt_o[i]),  m_cnt[i]);
        chk($sformatf("model_wrap[%0d]", i), int'(wrap_o[i]), m_wrap[i]);
        chk($sformatf("model_zero[%0d]", i), int'(zero_o[i]), (m_cnt[i] == 0) ? 1 : 0);
      end
    end
  end

  task automatic cyc(input logic rst, input logic en, input logic ud,
                     input logic ld, input logic [3:0] lv);
    reset = rst; enable = en; up_down = ud; load = ld; load_value = lv;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset dominates load and enable
    cyc(1, 1, 1, 1, 4'd5);
    cyc(1, 1, 1, 1, 4'd5);
    chk("reset_cnt",  int'(cnt_o[0]), 0);
    chk("reset_zero", int'(zero_o[0]), 1);
    chk("reset_wrap", int'(wrap_o[0]), 0);

    // Count up through the modulus
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 1, 1, 0, 4'd0);
      chk($sformatf("up_cnt_k%0d", k), int'(cnt_o[0]),
          sat ? ((k > 9) ? 9 : k) : (k % 10));
`ifndef COUNTER_SATURATE_EN
      chk($sformatf("up_wrap_k%0d", k), int'(wrap_o[0]), (k == 10) ? 1 : 0);
`endif
    end
`ifndef COUNTER_SATURATE_EN
    chk("up_wrap_zero", int'(zero_o[0]), 1);
`endif
    chk("div3_after10", int'(cnt_o[1]), 3);

`ifndef COUNTER_SATURATE_EN
    // Down wrap from 0
    cyc(0, 1, 0, 0, 4'd0);
    chk("down_wrap_cnt", int'(cnt_o[0]), 9);
    chk("down_wrap_pulse", int'(wrap_o[0]), 1);
    cyc(0, 1, 0, 0, 4'd0);
    chk("down_next_cnt", int'(cnt_o[0]), 8);
    chk("down_next_wrap", int'(wrap_o[0]), 0);
`endif

    // Prescale hold mid-period
    cyc(1, 0, 1, 0, 4'd0);
    for (int k = 0; k < 7; k++) cyc(0, 1, 1, 0, 4'd0);
    chk("div3_7cyc", int'(cnt_o[1]), 2);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 0, 4'd0);
      chk($sformatf("div3_hold%0d", k), int'(cnt_o[1]), 2);
    end
    cyc(0, 1, 1, 0, 4'd0);
    chk("div3_resume1", int'(cnt_o[1]), 2);
    cyc(0, 1, 1, 0, 4'd0);
    chk("div3_resume2", int'(cnt_o[1]), 3);

    // Load with clamp, then load over a coincident step
    cyc(0, 1, 1, 1, 4'd12);
    chk("load_clamp10", int'(cnt_o[0]), 9);
    chk("load_clamp10_d3", int'(cnt_o[1]), 9);
    chk("load_noclamp16", int'(cnt_o[2]), 12);
    cyc(0, 1, 1, 1, 4'd5);
    chk("load_step_cnt", int'(cnt_o[0]), 5);
    chk("load_step_wrap", int'(wrap_o[0]), 0);
    cyc(0, 1, 1, 0, 4'd0);
    chk("load_pre_clr1", int'(cnt_o[1]), 5);
    cyc(0, 1, 1, 0, 4'd0);
    chk("load_pre_clr2", int'(cnt_o[1]), 5);
    cyc(0, 1, 1, 0, 4'd0);
    chk("load_pre_clr3", int'(cnt_o[1]), 6);
    chk("load_then_d1", int'(cnt_o[0]), 8);

    // Full-range modulus (16 states in 4 bits)
    cyc(0, 0, 1, 1, 4'd15);
    chk("m16_load15", int'(cnt_o[2]), 15);
    cyc(0, 1, 1, 0, 4'd0);
    chk("m16_prescale", int'(cnt_o[2]), 15);
    cyc(0, 1, 1, 0, 4'd0);
    chk("m16_top_cnt", int'(cnt_o[2]), sat ? 15 : 0);
    chk("m16_top_wrap", int'(wrap_o[2]), sat ? 0 : 1);

`ifdef COUNTER_SATURATE_EN
    cyc(0, 0, 1, 1, 4'd9);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 4'd0);
      chk("sat_hi_cnt", int'(cnt_o[0]), 9);
      chk("sat_hi_wrap", int'(wrap_o[0]), 0);
    end
    cyc(0, 0, 0, 1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 4'd0);
      chk("sat_lo_cnt", int'(cnt_o[0]), 0);
      chk("sat_lo_zero", int'(zero_o[0]), 1);
    end
`endif

    // Direction changes between steps
    cyc(0, 1, 0, 0, 4'd0);
    cyc(0, 1, 1, 0, 4'd0);
    cyc(0, 1, 0, 0, 4'd0);
    cyc(0, 0, 1, 0, 4'd0);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
